// File: rtl/rot_enc_gen_pkg.sv
// Shared definitions for the quadrature encoder signal generator.
//   - register indices (addr[3:2])
//   - CTRL bit positions
//   - phase-to-{a,b} decode and a byte-strobe merge helper
package rot_enc_gen_pkg;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegPeriod = 2'd1;
  localparam logic [1:0] RegTarget = 2'd2;
  localparam logic [1:0] RegPos    = 2'd3;

  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlClrBit  = 1;
  localparam int unsigned CtrlBusyBit = 8;
  localparam int unsigned CtrlDoneBit = 9;

  // Gray-coded quadrature phase: A leads B when the phase counts up.
  function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
    logic [1:0] ab;
    unique case (phase)
      2'd0:    ab = 2'b00;
      2'd1:    ab = 2'b10;
      2'd2:    ab = 2'b11;
      default: ab = 2'b01;
    endcase
    return ab;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rot_enc_gen_step.sv
// Step engine: period timer, signed position counter, index counter and the
// registered a/b/z outputs.
//   clk_i, rst_ni    clock, async active-low reset
//   en_i             stepping enabled
//   clr_i            one-cycle clear of POS/IDX/timer (overrides a due step)
//   period_i         clocks per step (0 behaves as 1)
//   target_i         signed target position
//   pos_o            current position
//   busy_o           en && pos != target
//   step_hit_o       a step is taken this cycle and lands on the target
//   a_o, b_o, z_o    quadrature and index outputs
module rot_enc_gen_step
  import rot_enc_gen_pkg::*;
#(
  parameter int unsigned PPR   = 1024,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] period_i,
  input  logic [31:0]      target_i,
  output logic [31:0]      pos_o,
  output logic             busy_o,
  output logic             step_hit_o,
  output logic             a_o,
  output logic             b_o,
  output logic             z_o
);

  localparam int unsigned IdxMax = 4 * PPR;
  localparam int unsigned IdxW   = (IdxMax > 1) ? $clog2(IdxMax) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(IdxMax - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

  logic [DIV_W-1:0] timer_q, timer_d;
  logic [31:0]      pos_q, pos_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [1:0]       ab_q, ab_d;
  logic             z_q, z_d;

  logic [DIV_W:0]   timer_inc;
  logic [DIV_W-1:0] eff_period;
  logic             step_up;
  logic             step;

  assign busy_o = en_i && (pos_q != target_i);

  always_comb begin
    timer_d    = timer_q;
    pos_d      = pos_q;
    idx_d      = idx_q;
    step       = 1'b0;
    step_up    = $signed(target_i) > $signed(pos_q);
    eff_period = (period_i == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : period_i;
    timer_inc  = {1'b0, timer_q} + {{DIV_W{1'b0}}, 1'b1};

    if (clr_i) begin
      timer_d = '0;
      pos_d   = '0;
      idx_d   = '0;
    end else if (!busy_o) begin
      // Idle or disabled: a later enable/target starts a fresh full period.
      timer_d = '0;
    end else if (timer_inc >= {1'b0, eff_period}) begin
      // >= so that shrinking PERIOD mid-count steps at once instead of wrapping.
      step    = 1'b1;
      timer_d = '0;
      if (step_up) begin
        pos_d = pos_q + 32'd1;
        idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxOne;
      end else begin
        pos_d = pos_q - 32'd1;
        idx_d = (idx_q == '0) ? IdxLast : idx_q - IdxOne;
      end
    end else begin
      timer_d = timer_inc[DIV_W-1:0];
    end

    step_hit_o = step && (pos_d == target_i);
    ab_d       = phase_to_ab(pos_d[1:0]);
    z_d        = (idx_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
      pos_q   <= '0;
      idx_q   <= '0;
      ab_q    <= 2'b00;
      z_q     <= 1'b1;
    end else begin
      timer_q <= timer_d;
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      ab_q    <= ab_d;
      z_q     <= z_d;
    end
  end

  assign pos_o = pos_q;
  assign a_o   = ab_q[1];
  assign b_o   = ab_q[0];
  assign z_o   = z_q;

endmodule

// File: rtl/rot_enc_gen.sv
// Memory-mapped quadrature encoder generator (bus decode + register file).
// Walks an internal position toward a programmed signed target, one quadrature
// step every PERIOD clocks, driving a/b/z like an incremental encoder.
//   clk, resetn        clock, async active-low reset
//   valid/ready        bus request / one-cycle acknowledge
//   wstrb, addr, wdata byte strobes (0 = read), address (addr[3:2]), write data
//   rdata              read data, valid while ready=1
//   a, b, z            quadrature and index outputs
//   irq                done interrupt, only when ROT_ENC_GEN_IRQ_EN is defined
// Registers: 0 CTRL, 1 PERIOD, 2 TARGET, 3 POS (read-only).
module rot_enc_gen
  import rot_enc_gen_pkg::*;
#(
  parameter int unsigned PPR   = 1024,
  parameter int unsigned DIV_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        a,
  output logic        b,
  output logic        z
`ifdef ROT_ENC_GEN_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             en_q, en_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [31:0]      target_q, target_d;
  logic             done_q, done_d;

  logic        access;
  logic        clr;
  logic        done_clr;
  logic [31:0] period_wr;
  logic [31:0] ctrl_rd;
  logic [31:0] pos;
  logic        busy;
  logic        step_hit;

  // Accept only when no acknowledge is outstanding: at most one access per 2 cycles.
  assign access = valid && !ready_q;

  always_comb begin
    ready_d   = access;
    rdata_d   = '0;
    en_d      = en_q;
    period_d  = period_q;
    target_d  = target_q;
    clr       = 1'b0;
    done_clr  = 1'b0;
    period_wr = merge_bytes(32'(period_q), wdata, wstrb);

    ctrl_rd              = '0;
    ctrl_rd[CtrlEnBit]   = en_q;
    ctrl_rd[CtrlBusyBit] = busy;
    ctrl_rd[CtrlDoneBit] = done_q;

    if (access) begin
      if (wstrb == 4'b0000) begin
        unique case (addr[3:2])
          RegCtrl:   rdata_d = ctrl_rd;
          RegPeriod: rdata_d = 32'(period_q);
          RegTarget: rdata_d = target_q;
          default:   rdata_d = pos;
        endcase
      end else begin
        unique case (addr[3:2])
          RegCtrl: begin
            if (wstrb[0]) begin
              en_d = wdata[CtrlEnBit];
              clr  = wdata[CtrlClrBit];
            end
            if (wstrb[1]) done_clr = wdata[CtrlDoneBit];
          end
          RegPeriod: period_d = period_wr[DIV_W-1:0];
          RegTarget: target_d = merge_bytes(target_q, wdata, wstrb);
          default: ;
        endcase
      end
    end

`ifdef ROT_ENC_GEN_IRQ_EN
    // Set wins over a coincident clear.
    done_d = done_q;
    if (done_clr) done_d = 1'b0;
    if (step_hit) done_d = 1'b1;
`else
    done_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      en_q     <= 1'b0;
      period_q <= {{(DIV_W-1){1'b0}}, 1'b1};
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      en_q     <= en_d;
      period_q <= period_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;

`ifdef ROT_ENC_GEN_IRQ_EN
  assign irq = done_q;
  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], period_wr};
`else
  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], period_wr, step_hit, done_clr};
`endif

  rot_enc_gen_step #(
    .PPR  (PPR),
    .DIV_W(DIV_W)
  ) u_step (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .en_i      (en_q),
    .clr_i     (clr),
    .period_i  (period_q),
    .target_i  (target_q),
    .pos_o     (pos),
    .busy_o    (busy),
    .step_hit_o(step_hit),
    .a_o       (a),
    .b_o       (b),
    .z_o       (z)
  );

endmodule

// File: tb/tb_rot_enc_gen.sv
module tb_rot_enc_gen;

  localparam int unsigned PPR   = 1;
  localparam int unsigned DIV_W = 16;
  localparam int IDXN = 4 * PPR;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        a, b, z;
`ifdef ROT_ENC_GEN_IRQ_EN
  logic        irq;
`endif

  rot_enc_gen #(
    .PPR  (PPR),
    .DIV_W(DIV_W)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .valid (valid),
    .ready (ready),
    .wstrb (wstrb),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .a     (a),
    .b     (b),
    .z     (z)
`ifdef ROT_ENC_GEN_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit                m_en     = 1'b0;
  logic [DIV_W-1:0]  m_period = 1;
  logic [31:0]       m_target = '0;
  logic [31:0]       m_pos    = '0;
  int                m_idx    = 0;
  int unsigned       m_cnt    = 0;
  bit                m_done   = 1'b0;

  // Request mailbox from the stimulus task to the model.
  int          req_seq = 0;
  int          served  = 0;
  bit          req_wr;
  logic [1:0]  req_reg;
  logic [3:0]  req_strb;
  logic [31:0] req_data;

  typedef struct {
    bit          is_rd;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [1:0] ab_of(input logic [31:0] p);
    logic [1:0] ph;
    ph = p[1:0];
    case (ph)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    bit          wr_now, clr_now, dclr, set_done, moving;
    logic [31:0] rd, merged;
    exp_t        e;
    int          dir;
    int unsigned eff;
    if (!resetn) begin
      m_en = 0; m_period = 1; m_target = '0; m_pos = '0; m_idx = 0; m_cnt = 0; m_done = 0;
      served = req_seq;
      exp_q.delete();
    end else begin
      wr_now = 0; clr_now = 0; dclr = 0; set_done = 0;
      if (served != req_seq) begin
        served = req_seq;
        rd = '0;
        if (!req_wr) begin
          case (req_reg)
            2'd0: begin
              rd[0] = m_en;
              rd[8] = m_en && (m_pos != m_target);
`ifdef ROT_ENC_GEN_IRQ_EN
              rd[9] = m_done;
`endif
            end
            2'd1: rd = 32'(m_period);
            2'd2: rd = m_target;
            default: rd = m_pos;
          endcase
        end else begin
          wr_now = 1;
          if (req_reg == 2'd0 && req_strb[0] && req_data[1]) clr_now = 1;
          if (req_reg == 2'd0 && req_strb[1] && req_data[9]) dclr = 1;
        end
        e.is_rd = !req_wr;
        e.val   = rd;
        exp_q.push_back(e);
      end

      moving = m_en && (m_pos != m_target);
      eff = (m_period == 0) ? 1 : int'(m_period);
      if (clr_now) begin
        m_pos = '0; m_idx = 0; m_cnt = 0;
      end else if (!moving) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt >= eff) begin
          m_cnt = 0;
          dir = ($signed(m_target) > $signed(m_pos)) ? 1 : -1;
          m_pos = m_pos + 32'(dir);
          m_idx = (m_idx + dir + IDXN) % IDXN;
          if (m_pos == m_target) set_done = 1;
        end
      end
      if (dclr) m_done = 0;
      if (set_done) m_done = 1;

      if (wr_now) begin
        case (req_reg)
          2'd0: if (req_strb[0]) m_en = req_data[0];
          2'd1: begin
            merged = 32'(m_period);
            for (int i = 0; i < 4; i++) if (req_strb[i]) merged[8*i +: 8] = req_data[8*i +: 8];
            m_period = merged[DIV_W-1:0];
          end
          2'd2: begin
            for (int i = 0; i < 4; i++) if (req_strb[i]) m_target[8*i +: 8] = req_data[8*i +: 8];
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      check("abz", {29'd0, a, b, z}, {29'd0, ab_of(m_pos), (m_idx == 0)});
`ifdef ROT_ENC_GEN_IRQ_EN
      check("irq", {31'd0, irq}, {31'd0, m_done});
`endif
      if (ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_ready", 32'(ready), 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_rd) check("rdata", rdata, e.val);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus(input bit wr, input logic [1:0] r, input logic [31:0] data,
                     input logic [3:0] strb, output logic [31:0] rd_val);
    bit got;
    @(negedge clk);
    valid = 1'b1;
    addr  = {28'd0, r, 2'b00};
    wdata = data;
    wstrb = wr ? strb : 4'h0;
    req_wr = wr; req_reg = r; req_strb = wr ? strb : 4'h0; req_data = data;
    req_seq++;
    got = 0;
    rd_val = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1;
        rd_val = rdata;
        break;
      end
    end
    valid = 1'b0;
    wstrb = 4'h0;
    if (!got) check("bus_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] data);
    logic [31:0] dummy;
    bus(1'b1, r, data, 4'hF, dummy);
  endtask

  task automatic rd(input logic [1:0] r, output logic [31:0] v);
    bus(1'b0, r, '0, 4'h0, v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] v;
  logic [31:0] ctrl_done_exp;
  logic [2:0]  frozen;

  initial begin
`ifdef ROT_ENC_GEN_IRQ_EN
    ctrl_done_exp = 32'h201;
`else
    ctrl_done_exp = 32'h1;
`endif
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Reset state
    check("rst_abz", {29'd0, a, b, z}, 32'h1);
    rd(2'd0, v); check("rst_ctrl", v, 32'h0);
    rd(2'd1, v); check("rst_period", v, 32'h1);
    rd(2'd2, v); check("rst_target", v, 32'h0);
    rd(2'd3, v); check("rst_pos", v, 32'h0);

    // Three forward steps at PERIOD=4
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h1);
    idle(20);
    rd(2'd3, v); check("move3_pos", v, 32'd3);
    rd(2'd0, v); check("move3_ctrl", v, ctrl_done_exp);
    check("move3_abz", {29'd0, a, b, z}, {29'd0, 3'b010});
`ifdef ROT_ENC_GEN_IRQ_EN
    wr(2'd0, 32'h201);
    check("irq_clr", {31'd0, irq}, 32'd0);
`endif

    // Backward step past zero with PPR=1
    wr(2'd0, 32'h0);
    wr(2'd0, 32'h2);
    wr(2'd1, 32'd1);
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd0, 32'h1);
    idle(5);
    check("neg_abz", {29'd0, a, b, z}, {29'd0, 3'b010});
    rd(2'd3, v); check("neg_pos", v, 32'hFFFF_FFFF);
    wr(2'd2, 32'h0);
    idle(5);
    check("back0_abz", {29'd0, a, b, z}, 32'h1);

    // Mid-move redirect
    wr(2'd1, 32'd2);
    wr(2'd2, 32'd100);
    for (int i = 0; i < 200 && m_pos != 32'd5; i++) @(negedge clk);
    check("reach5", m_pos, 32'd5);
    wr(2'd2, 32'hFFFF_FFFE);
    for (int i = 0; i < 400 && m_pos != 32'hFFFF_FFFE; i++) @(negedge clk);
    rd(2'd3, v); check("redirect_pos", v, 32'hFFFF_FFFE);

    // CLR on the edge a step is due
    wr(2'd0, 32'h0);
    wr(2'd0, 32'h2);
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd100);
    wr(2'd0, 32'h1);   // enable at edge E
    rd(2'd0, v);       // edge E+2
    wr(2'd0, 32'h3);   // CLR at E+4, where the first step is due
    rd(2'd3, v); check("clr_pos", v, 32'd0);
    wr(2'd0, 32'h0);
    frozen = {a, b, z};
    idle(20);
    check("frozen_abz", {29'd0, a, b, z}, {29'd0, frozen});
    rd(2'd3, v); check("frozen_pos", v, 32'd1);

    // Randomised traffic
    wr(2'd0, 32'h1);
    for (int n = 0; n < 300; n++) begin
      int op;
      logic [31:0] d;
      logic [3:0]  s;
      op = $urandom_range(0, 9);
      s  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
      case (op)
        0, 1, 2: rd(2'($urandom_range(0, 3)), v);
        3: begin
          d = m_pos + 32'($urandom_range(0, 12)) - 32'd6;
          bus(1'b1, 2'd2, d, s, v);
        end
        4: bus(1'b1, 2'd1, 32'($urandom_range(0, 4)), s, v);
        5: begin
          d = '0;
          d[0] = ($urandom_range(0, 3) != 0);
          d[1] = ($urandom_range(0, 7) == 0);
          d[9] = $urandom_range(0, 1);
          bus(1'b1, 2'd0, d, s, v);
        end
        6: bus(1'b1, 2'd3, $urandom, 4'hF, v);
        default: idle($urandom_range(0, 8));
      endcase
    end
    idle(10);

    // Reset asserted while a write is being presented
    @(negedge clk);
    valid  = 1'b1;
    addr   = {28'd0, 2'd2, 2'b00};
    wdata  = 32'd55;
    wstrb  = 4'hF;
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", {31'd0, ready}, 32'd0);
    check("rst_mid_abz", {29'd0, a, b, z}, 32'h1);
    valid  = 1'b0;
    wstrb  = 4'h0;
    @(negedge clk);
    resetn = 1'b1;
    rd(2'd2, v); check("rst_mid_target", v, 32'd0);
    rd(2'd0, v); check("rst_mid_ctrl", v, 32'd0);
    idle(3);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
